// File: rtl/quant_writeback_ctrl_if.sv
// Row-input handshake and SRAM write bus of the quantize/writeback sequencer.
// master: the side that produces raw rows and owns the SRAM.
// slave:  the sequencer itself.
`timescale 1ns/1ps
interface quant_writeback_ctrl_if #(
  parameter int ARRAY_SIZE      = 8,
  parameter int ORI_WIDTH       = 21,
  parameter int ADDR_WIDTH      = 10,
  parameter int SRAM_DATA_WIDTH = 32
);
  logic                            in_valid;
  logic                            in_ready;
  logic [ARRAY_SIZE*ORI_WIDTH-1:0] in_data;
  logic                            sram_we;
  logic [ADDR_WIDTH-1:0]           sram_addr;
  logic [SRAM_DATA_WIDTH-1:0]      sram_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/quant_writeback_ctrl.sv
// Accepts rows of raw accumulator sums, saturates each element to a signed
// 16-bit value, and writes the packed row to SRAM as a burst of consecutive
// words. Jobs of num_rows rows are launched by start and end with a done pulse.
`timescale 1ns/1ps
module quant_writeback_ctrl #(
  parameter int ARRAY_SIZE        = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH        = 10
) (
  input  logic                    clk,
  input  logic                    srstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              num_rows,
  quant_writeback_ctrl_if.slave   bus,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             sat_count
);

  localparam int ORI_WIDTH = 2*DATA_WIDTH + 5;
  localparam int ROW_BITS  = ARRAY_SIZE*OUTPUT_DATA_WIDTH;
  localparam int W         = ROW_BITS / SRAM_DATA_WIDTH;
  localparam int WCW       = (W > 1) ? $clog2(W) : 1;

  // Saturation limits in the raw domain; NEG_LIM is the two's complement
  // partner of POS_LIM (~32767 == -32768).
  localparam logic signed [ORI_WIDTH-1:0] POS_LIM = ORI_WIDTH'(2**(OUTPUT_DATA_WIDTH-1) - 1);
  localparam logic signed [ORI_WIDTH-1:0] NEG_LIM = ~POS_LIM;
  localparam logic [OUTPUT_DATA_WIDTH-1:0] QMAX = {1'b0, {(OUTPUT_DATA_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_DATA_WIDTH-1:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [7:0]             num_rows_reg;
  logic [7:0]             row_idx_reg;
  logic [WCW-1:0]         word_cnt_reg;
  logic [ROW_BITS-1:0]    row_buf_reg;
  logic [15:0]            sat_reg;

  logic                   job_start;
  logic                   accept;
  logic                   write_step;
  logic                   last_word;
  logic [8:0]             row_inc;

  logic [ROW_BITS-1:0]    quant_row;
  logic [ARRAY_SIZE-1:0]  clip_flag;
  logic [15:0]            clip_num;
  logic [16:0]            sat_sum;
  logic [15:0]            sat_next;

  // Per-element saturation. The exact limits map to themselves without
  // being flagged, so only true clipping contributes to the statistic.
  generate
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_quant
      logic signed [ORI_WIDTH-1:0] x;
      assign x = $signed(bus.in_data[gi*ORI_WIDTH +: ORI_WIDTH]);
      assign quant_row[gi*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] =
          (x >= POS_LIM) ? QMAX :
          (x <= NEG_LIM) ? QMIN : x[OUTPUT_DATA_WIDTH-1:0];
      assign clip_flag[gi] = (x > POS_LIM) || (x < NEG_LIM);
    end
  endgenerate

  // Count clipped elements of the incoming row and add with saturation.
  always_comb begin
    clip_num = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      clip_num = clip_num + 16'(clip_flag[i]);
    end
    sat_sum  = {1'b0, sat_reg} + {1'b0, clip_num};
    sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  assign row_inc = {1'b0, row_idx_reg} + 9'd1;

  // State register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state_reg;
    job_start  = 1'b0;
    accept     = 1'b0;
    write_step = 1'b0;
    last_word  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          job_start  = 1'b1;
          state_next = (num_rows == 8'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        write_step = 1'b1;
        if (word_cnt_reg == WCW'(W-1)) begin
          last_word  = 1'b1;
          state_next = (row_inc < {1'b0, num_rows_reg}) ? LOAD : DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job parameters, row buffer and counters. The write address is kept as a
  // running pointer, which equals base + row_idx*W + word_cnt modulo 2^ADDR_WIDTH
  // and stays contiguous across input stalls.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      addr_reg     <= '0;
      num_rows_reg <= '0;
      row_idx_reg  <= '0;
      word_cnt_reg <= '0;
      row_buf_reg  <= '0;
      sat_reg      <= '0;
    end else begin
      if (job_start) begin
        addr_reg     <= base_addr;
        num_rows_reg <= num_rows;
        row_idx_reg  <= '0;
        word_cnt_reg <= '0;
        sat_reg      <= '0;
      end
      if (accept) begin
        row_buf_reg  <= quant_row;
        sat_reg      <= sat_next;
        word_cnt_reg <= '0;
      end
      if (write_step) begin
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
        if (last_word) begin
          row_idx_reg  <= row_idx_reg + 8'd1;
          word_cnt_reg <= '0;
        end else begin
          word_cnt_reg <= word_cnt_reg + WCW'(1);
        end
      end
    end
  end

  // Outputs decode registered state only; address and data read as zero
  // whenever no write is in progress.
  assign bus.in_ready   = (state_reg == LOAD);
  assign bus.sram_we    = (state_reg == WRITE);
  assign bus.sram_addr  = bus.sram_we ? addr_reg : '0;
  assign bus.sram_wdata = bus.sram_we ?
      row_buf_reg[int'(word_cnt_reg)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] : '0;
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign sat_count      = sat_reg;

endmodule

// File: tb/tb_quant_writeback_ctrl.sv
// Directed bench: stimulus pushes expected SRAM words into a queue, a monitor
// pops and compares on every write strobe.
`timescale 1ns/1ps
module tb_quant_writeback_ctrl;

  logic        clk = 1'b0;
  logic        srstn;
  logic        start;
  logic [9:0]  base_addr;
  logic [7:0]  num_rows;
  logic        busy;
  logic        done;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  quant_writeback_ctrl_if #(
    .ARRAY_SIZE(8), .ORI_WIDTH(21), .ADDR_WIDTH(10), .SRAM_DATA_WIDTH(32)
  ) bus ();

  quant_writeback_ctrl #(
    .ARRAY_SIZE(8), .DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(16),
    .SRAM_DATA_WIDTH(32), .ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .bus(bus), .busy(busy), .done(done),
    .sat_count(sat_count)
  );

  int          total = 0;
  int          bad   = 0;
  logic [41:0] exp_q[$];
  logic [9:0]  exp_addr = '0;
  int          done_cnt = 0;
  logic        last_we = 1'b0;
  logic        job_rows = 1'b0;

  // Hand-computed packed words, word 0 in the low 32 bits.
  localparam logic [127:0] WORDS_A = {32'h07000600, 32'h05000400, 32'h03000200, 32'h01000000};
  localparam logic [127:0] WORDS_S = {32'h00010000, 32'hFFFF0064, 32'h80007FFF, 32'h80007FFF};
  localparam logic [127:0] WORDS_C = {32'hFF0000FF, 32'h80007FFF, 32'h80017FFE, 32'h0002FFFE};

  logic [167:0] row_a, row_s, row_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [167:0] mkrow(input int e0, input int e1, input int e2, input int e3,
                                         input int e4, input int e5, input int e6, input int e7);
    logic [167:0] r;
    int e[8];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    e[4] = e4; e[5] = e5; e[6] = e6; e[7] = e7;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*21 +: 21] = 21'(e[i]);
    return r;
  endfunction

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [41:0] e;
    if (srstn) begin
      if (bus.sram_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write",
                   bus.sram_addr, bus.sram_wdata);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=0x%03h data=0x%08h", bus.sram_addr, bus.sram_wdata);
          check("wr_addr", 32'(bus.sram_addr), 32'(e[41:32]));
          check("wr_data", bus.sram_wdata, e[31:0]);
        end
        check("in_ready_during_write", 32'(bus.in_ready), 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        if (job_rows) check("done_after_last_write", 32'(last_we), 32'd1);
      end
      last_we = bus.sram_we;
    end else begin
      last_we = 1'b0;
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),   32'd0);
    check({tag, "_sram_we"},   32'(bus.sram_we),    32'd0);
    check({tag, "_sram_addr"}, 32'(bus.sram_addr),  32'd0);
    check({tag, "_sram_wdata"}, bus.sram_wdata,     32'd0);
    check({tag, "_busy"},      32'(busy),           32'd0);
    check({tag, "_done"},      32'(done),           32'd0);
    check({tag, "_sat_count"}, 32'(sat_count),      32'd0);
  endtask

  task automatic go(input logic [9:0] b, input logic [7:0] n);
    base_addr = b;
    num_rows  = n;
    start     = 1'b1;
    exp_addr  = b;
    job_rows  = (n != 8'd0);
    @(posedge clk);
    #1 start = 1'b0;
    $display("start base=0x%03h rows=%0d", b, n);
  endtask

  task automatic run_row(input logic [167:0] data, input logic [127:0] words, input int gap);
    bit accepted = 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back({exp_addr, words[w*32 +: 32]});
      exp_addr = exp_addr + 10'd1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      bus.in_valid = 1'b0;
      total++;
      bad++;
      $display("FAIL row_accept_timeout actual=no in_ready required=in_ready within 100 cycles");
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=no done required=done within 300 cycles");
    end else begin
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("done_single_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int d0;
    row_a = mkrow(0, 256, 512, 768, 1024, 1280, 1536, 1792);
    row_s = mkrow(40000, -40000, 32767, -32768, 100, -1, 0, 1);
    row_c = mkrow(-2, 2, 32766, -32767, 65536, -65536, 255, -256);

    srstn = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    #1 check_zero_outputs("por");
    repeat (2) @(posedge clk);
    #1 srstn = 1'b1;

    // Single row, elements i*256.
    d0 = done_cnt;
    go(10'h010, 8'd1);
    check("busy_cycle1", 32'(busy), 32'd1);
    check("in_ready_cycle1", 32'(bus.in_ready), 32'd1);
    run_row(row_a, WORDS_A, 0);
    wait_done();
    check("single_sat", 32'(sat_count), 32'd0);
    check("single_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Saturation corners.
    go(10'h010, 8'd1);
    run_row(row_s, WORDS_S, 1);
    wait_done();
    check("sat_count_2", 32'(sat_count), 32'd2);

    // Multi-row with idle gaps; statistic restarts at the new job.
    d0 = done_cnt;
    go(10'h020, 8'd3);
    check("sat_cleared_at_start", 32'(sat_count), 32'd0);
    run_row(row_a, WORDS_A, 0);
    run_row(row_s, WORDS_S, 3);
    run_row(row_c, WORDS_C, 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("multi_sat", 32'(sat_count), 32'd4);
    check("multi_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("sat_held_idle", 32'(sat_count), 32'd4);

    // Address wrap.
    go(10'h3FE, 8'd1);
    run_row(row_a, WORDS_A, 0);
    wait_done();

    // Zero-row job.
    d0 = done_cnt;
    go(10'h070, 8'd0);
    check("zero_done_cycle1", 32'(done), 32'd1);
    check("zero_busy_cycle1", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("zero_idle_busy", 32'(busy), 32'd0);
    check("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    // start pulsed while writing must not disturb the burst.
    d0 = done_cnt;
    go(10'h040, 8'd1);
    run_row(row_a, WORDS_A, 0);
    base_addr = 10'h100; num_rows = 8'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("start_in_write_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("start_in_write_busy", 32'(busy), 32'd0);

    // Reset during the second word of a burst.
    go(10'h050, 8'd2);
    run_row(row_c, WORDS_C, 0);
    @(posedge clk);
    #2 srstn = 1'b0;
    #1 check_zero_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 srstn = 1'b1;

    // Fresh job after reset.
    go(10'h060, 8'd1);
    run_row(row_s, WORDS_S, 0);
    wait_done();
    check("post_reset_sat", 32'(sat_count), 32'd2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
